// File: rtl/program_loader.sv
// program_loader: frames sync/len/hi-lo byte pairs from the host link into program RAM writes, holding the CPU meanwhile.
// Define CHECKSUM_EN to require a trailing mod-256 checksum byte per frame.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);
`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, DONE, CSUM} state_t;
  localparam state_t LAST_ST = CSUM;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, DONE} state_t;
  localparam state_t LAST_ST = DONE;
`endif
  state_t state_q, state_d;
  logic [8:0] count_q;
  logic [7:0] hi_q;
  logic accept;
  assign rx_ready  = state_q != WR && state_q != DONE;
  assign accept    = rx_valid && rx_ready;
  assign mem_we    = state_q == WR;
  assign load_done = state_q == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept && rx_data == SYNC_BYTE ? LEN : IDLE;
      LEN:  state_d = accept ? HI : LEN;
      HI:   state_d = accept ? LO : HI;
      LO:   state_d = accept ? WR : LO;
      WR:   state_d = count_q == 9'd1 ? LAST_ST : HI;
`ifdef CHECKSUM_EN
      CSUM: state_d = accept ? (rx_data == csum_q ? DONE : IDLE) : CSUM;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_addr <= ADDR_WIDTH'(BASE_ADDR);
      mem_din  <= '0;
      cpu_hold <= 1'b0;
      count_q  <= '0;
      hi_q     <= '0;
`ifdef CHECKSUM_EN
      csum_q   <= '0;
      load_err <= 1'b0;
`endif
    end else
      case (state_q)
        IDLE: if (accept && rx_data == SYNC_BYTE) begin
          cpu_hold <= 1'b1;
          mem_addr <= ADDR_WIDTH'(BASE_ADDR);
`ifdef CHECKSUM_EN
          csum_q   <= '0;
          load_err <= 1'b0;
`endif
        end
        LEN: if (accept) count_q <= rx_data == 8'd0 ? 9'd256 : {1'b0, rx_data};
        HI: if (accept) begin
          hi_q <= rx_data;
`ifdef CHECKSUM_EN
          csum_q <= csum_q + rx_data;
`endif
        end
        LO: if (accept) begin
          mem_din <= DATA_WIDTH'({hi_q, rx_data});
`ifdef CHECKSUM_EN
          csum_q <= csum_q + rx_data;
`endif
        end
        WR: begin
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
          count_q  <= count_q - 9'd1;
        end
`ifdef CHECKSUM_EN
        CSUM: if (accept && rx_data != csum_q) begin
          load_err <= 1'b1;
          cpu_hold <= 1'b0;
        end
`endif
        DONE: cpu_hold <= 1'b0;
        default: ;
      endcase
`ifndef CHECKSUM_EN
  assign load_err = 1'b0;
`endif
endmodule
